// File: rtl/scurve_seq_pkg.sv
// scurve_seq_pkg: shared types for the S-curve DAQ sequencer
// state encoding and default sizing constants
package scurve_seq_pkg;

  localparam int DAC_WIDTH_DEF = 10;
  localparam int RUN_WIDTH_DEF = 16;
  localparam int TIMEOUT_DEF   = 4000000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_SC   = 3'd1,
    WAIT_SC   = 3'd2,
    START_RUN = 3'd3,
    WAIT_RUN  = 3'd4,
    NEXT_STEP = 3'd5,
    DONE      = 3'd6
  } seq_state_t;

endpackage

// File: rtl/seq_timeout_timer.sv
// seq_timeout_timer: watchdog cycle counter with clear and enable
// expired is high on the last allowed cycle; TIMEOUT_CYCLES=0 never expires
module seq_timeout_timer
  import scurve_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
)(
  input  logic Clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LIM =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] LIM_V = CW'(LIM);
  localparam bit WD_ON = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt;

  // count enabled cycles, hold at the limit
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LIM_V) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = WD_ON && en && (cnt == LIM_V);

endmodule

// File: rtl/scurve_daq_sequencer.sv
// scurve_daq_sequencer: threshold sweep sequencer for S-curve scans
// optional trigger counting enabled by SCURVE_TRIG_COUNT_EN
module scurve_daq_sequencer
  import scurve_seq_pkg::*;
#(
  parameter int DAC_WIDTH      = DAC_WIDTH_DEF,
  parameter int RUN_WIDTH      = RUN_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
)(
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 Sweep_Start,
  input  logic                 Sweep_Stop,
  input  logic [DAC_WIDTH-1:0] Dac_Start,
  input  logic [DAC_WIDTH-1:0] Dac_End,
  input  logic [DAC_WIDTH-1:0] Dac_Step,
  input  logic [RUN_WIDTH-1:0] Runs_Per_Step,
  output logic                 Sc_Req,
  output logic [DAC_WIDTH-1:0] Sc_Dac,
  input  logic                 Sc_Done,
  output logic                 Daq_Start,
  input  logic                 Once_end,
  output logic                 Busy,
  output logic                 Step_Strobe,
  output logic                 Sweep_Done,
  output logic                 Timeout_Err,
`ifdef SCURVE_TRIG_COUNT_EN
  input  logic                 Trig_In,
  output logic [31:0]          Trig_Count,
  output logic                 Trig_Count_Valid,
`endif
  output logic [RUN_WIDTH-1:0] Run_Count
);

  seq_state_t state_q;
  seq_state_t state_d;

  logic [DAC_WIDTH-1:0] end_q;
  logic [DAC_WIDTH-1:0] step_q;
  logic [RUN_WIDTH-1:0] runs_q;
  logic                 abort_q;
  logic                 abort;
  logic                 waiting;
  logic                 tmo;
  logic [DAC_WIDTH:0]   nxt;
  logic                 last_step;
  logic [RUN_WIDTH-1:0] run_inc;

  logic sc_req_d;
  logic daq_start_d;
  logic step_strobe_d;
  logic sweep_done_d;
  logic timeout_err_d;

  assign abort   = abort_q | Sweep_Stop;
  assign waiting = (state_q == WAIT_SC) ||
                   (state_q == WAIT_RUN);
  assign nxt     = {1'b0, Sc_Dac} + {1'b0, step_q};
  assign run_inc = Run_Count + 1'b1;
  assign Busy    = (state_q != IDLE);

  // stop after this code if at end or next code overshoots
  assign last_step = (Sc_Dac >= end_q) ||
                     nxt[DAC_WIDTH] ||
                     (nxt > {1'b0, end_q});

  seq_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .Clk    (Clk),
    .reset  (reset),
    .clr    (!waiting),
    .en     (waiting),
    .expired(tmo)
  );

  // state register
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode; handshake events win over the watchdog
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (Sweep_Start) state_d = LOAD_SC;
      end
      LOAD_SC: begin
        state_d = WAIT_SC;
      end
      WAIT_SC: begin
        if (Sc_Done) begin
          state_d = abort ? DONE : START_RUN;
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      START_RUN: begin
        state_d = abort ? DONE : WAIT_RUN;
      end
      WAIT_RUN: begin
        if (Once_end) begin
          if (abort) begin
            state_d = DONE;
          end else if (run_inc < runs_q) begin
            state_d = START_RUN;
          end else begin
            state_d = NEXT_STEP;
          end
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      NEXT_STEP: begin
        state_d = (last_step || abort) ? DONE : LOAD_SC;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // output decode; outputs are registered one cycle later
  always_comb begin
    sc_req_d      = (state_d == WAIT_SC);
    daq_start_d   = (state_q == START_RUN) &&
                    (state_d == WAIT_RUN);
    step_strobe_d = (state_q == NEXT_STEP);
    sweep_done_d  = (state_q == DONE);
    timeout_err_d = Timeout_Err;
    if (state_q == IDLE && Sweep_Start) begin
      timeout_err_d = 1'b0;
    end else if (waiting && state_d == IDLE) begin
      timeout_err_d = 1'b1;
    end
  end

  // registered control outputs
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      Sc_Req      <= 1'b0;
      Daq_Start   <= 1'b0;
      Step_Strobe <= 1'b0;
      Sweep_Done  <= 1'b0;
      Timeout_Err <= 1'b0;
    end else begin
      Sc_Req      <= sc_req_d;
      Daq_Start   <= daq_start_d;
      Step_Strobe <= step_strobe_d;
      Sweep_Done  <= sweep_done_d;
      Timeout_Err <= timeout_err_d;
    end
  end

  // sweep settings, current code, run counter and pending abort
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      Sc_Dac    <= '0;
      end_q     <= '0;
      step_q    <= '0;
      runs_q    <= '0;
      Run_Count <= '0;
      abort_q   <= 1'b0;
    end else if (state_q == IDLE) begin
      abort_q <= 1'b0;
      if (Sweep_Start) begin
        Sc_Dac    <= Dac_Start;
        end_q     <= Dac_End;
        step_q    <= (Dac_Step == '0) ?
                     DAC_WIDTH'(1) : Dac_Step;
        runs_q    <= (Runs_Per_Step == '0) ?
                     RUN_WIDTH'(1) : Runs_Per_Step;
        Run_Count <= '0;
        abort_q   <= Sweep_Stop;
      end
    end else begin
      if (Sweep_Stop) abort_q <= 1'b1;
      if (state_q == WAIT_RUN && Once_end) begin
        Run_Count <= run_inc;
      end
      if (state_q == NEXT_STEP) begin
        Run_Count <= '0;
        if (state_d == LOAD_SC) begin
          Sc_Dac <= nxt[DAC_WIDTH-1:0];
        end
      end
    end
  end

`ifdef SCURVE_TRIG_COUNT_EN
  logic [31:0] trig_cnt_q;

  // saturating trigger count per code, frozen at step end
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      trig_cnt_q       <= '0;
      Trig_Count       <= '0;
      Trig_Count_Valid <= 1'b0;
    end else begin
      Trig_Count_Valid <= (state_q == NEXT_STEP);
      if (state_q == NEXT_STEP) begin
        Trig_Count <= trig_cnt_q;
      end
      if (state_q != LOAD_SC && state_d == LOAD_SC) begin
        trig_cnt_q <= '0;
      end else if (state_q == WAIT_RUN && Trig_In &&
                   trig_cnt_q != '1) begin
        trig_cnt_q <= trig_cnt_q + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_scurve_daq_sequencer.sv
// tb_scurve_daq_sequencer: directed plus randomized sweeps
// checked against a code-list model of the sweep rules
module tb_scurve_daq_sequencer;

  localparam int DW = 10;
  localparam int RW = 16;
  localparam int TO = 50;

  logic          Clk = 1'b0;
  logic          reset = 1'b1;
  logic          Sweep_Start = 1'b0;
  logic          Sweep_Stop = 1'b0;
  logic [DW-1:0] Dac_Start = '0;
  logic [DW-1:0] Dac_End = '0;
  logic [DW-1:0] Dac_Step = '0;
  logic [RW-1:0] Runs_Per_Step = '0;
  logic          Sc_Req;
  logic [DW-1:0] Sc_Dac;
  logic          Sc_Done = 1'b0;
  logic          Daq_Start;
  logic          Once_end = 1'b0;
  logic          Busy;
  logic          Step_Strobe;
  logic          Sweep_Done;
  logic          Timeout_Err;
  logic [RW-1:0] Run_Count;

  scurve_daq_sequencer #(
    .DAC_WIDTH     (DW),
    .RUN_WIDTH     (RW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk          (Clk),
    .reset        (reset),
    .Sweep_Start  (Sweep_Start),
    .Sweep_Stop   (Sweep_Stop),
    .Dac_Start    (Dac_Start),
    .Dac_End      (Dac_End),
    .Dac_Step     (Dac_Step),
    .Runs_Per_Step(Runs_Per_Step),
    .Sc_Req       (Sc_Req),
    .Sc_Dac       (Sc_Dac),
    .Sc_Done      (Sc_Done),
    .Daq_Start    (Daq_Start),
    .Once_end     (Once_end),
    .Busy         (Busy),
    .Step_Strobe  (Step_Strobe),
    .Sweep_Done   (Sweep_Done),
    .Timeout_Err  (Timeout_Err),
    .Run_Count    (Run_Count)
  );

  always #5 Clk = ~Clk;

  int nchk = 0;
  int npass = 0;
  int nfail = 0;

  int ncyc = 0;
  int sc_cnt = -1;
  int run_cnt = -1;
  int sc_lat = 5;
  int run_lat = 5;
  bit hold_run = 1'b0;
  bit stray = 1'b0;
  logic sc_req_prev = 1'b0;
  logic tmo_prev = 1'b0;

  int codes[$];
  int daq_t[$];
  int scdone_t[$];
  int oe_t[$];
  int screq_t[$];
  int exp_codes[$];
  int strobe_cnt;
  int done_cnt;
  int done_t;
  int tmo_t;
  int start_t;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // responder for Sc_Done / Once_end plus event log
  always @(negedge Clk) begin
    ncyc++;
    Sc_Done = 1'b0;
    Once_end = 1'b0;
    if (reset) begin
      sc_cnt = -1;
      run_cnt = -1;
    end else begin
      if (Sweep_Start) start_t = ncyc;
      if (Sc_Req && !sc_req_prev) begin
        codes.push_back(int'(Sc_Dac));
        screq_t.push_back(ncyc);
      end
      if (Daq_Start) daq_t.push_back(ncyc);
      if (Step_Strobe) strobe_cnt++;
      if (Sweep_Done) begin
        done_cnt++;
        done_t = ncyc;
      end
      if (Timeout_Err && !tmo_prev) tmo_t = ncyc;
      if (sc_cnt > 0) begin
        sc_cnt--;
        if (sc_cnt == 0) begin
          Sc_Done = 1'b1;
          scdone_t.push_back(ncyc);
          sc_cnt = -1;
        end else if (stray && sc_cnt == 2) begin
          Once_end = 1'b1;
        end
      end else if (sc_cnt < 0 && Sc_Req && !sc_req_prev) begin
        sc_cnt = sc_lat;
      end
      if (run_cnt > 0) begin
        run_cnt--;
        if (run_cnt == 0) begin
          Once_end = 1'b1;
          oe_t.push_back(ncyc);
          run_cnt = -1;
        end else if (stray && run_cnt == 2) begin
          Sc_Done = 1'b1;
        end
      end else if (run_cnt < 0 && Daq_Start && !hold_run) begin
        run_cnt = run_lat;
      end
    end
    sc_req_prev = Sc_Req;
    tmo_prev = Timeout_Err;
  end

  task automatic clear_log();
    codes.delete();
    daq_t.delete();
    scdone_t.delete();
    oe_t.delete();
    screq_t.delete();
    strobe_cnt = 0;
    done_cnt = 0;
    done_t = -1;
    tmo_t = -1;
    start_t = -1;
  endtask

  // expected code list from the sweep rules
  task automatic model(input int s, input int e, input int st);
    int stp;
    int c;
    int n;
    exp_codes.delete();
    stp = (st == 0) ? 1 : st;
    c = s;
    for (int k = 0; k < 2000; k++) begin
      exp_codes.push_back(c);
      n = c + stp;
      if (c >= e || n > e || n > 1023) break;
      c = n;
    end
  endtask

  task automatic do_sweep(input int s, input int e,
                          input int st, input int r,
                          input int stop_n, input int budget,
                          input bit both);
    bit fin;
    bit stopped;
    clear_log();
    Dac_Start = DW'(s);
    Dac_End = DW'(e);
    Dac_Step = DW'(st);
    Runs_Per_Step = RW'(r);
    @(posedge Clk); #1;
    Sweep_Start = 1'b1;
    Sweep_Stop = both;
    @(posedge Clk); #1;
    Sweep_Start = 1'b0;
    Sweep_Stop = 1'b0;
    Dac_Start = DW'($urandom);
    Dac_End = DW'($urandom);
    Dac_Step = DW'($urandom);
    Runs_Per_Step = RW'($urandom);
    fin = 1'b0;
    stopped = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge Clk); #1;
      Sweep_Stop = 1'b0;
      if (stop_n > 0 && !stopped && daq_t.size() == stop_n &&
          ncyc >= daq_t[$] + 2) begin
        Sweep_Stop = 1'b1;
        stopped = 1'b1;
      end
      if (done_cnt > 0 || Timeout_Err) begin
        fin = 1'b1;
        break;
      end
    end
    Sweep_Stop = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    check("sweep_finished", 32'(fin), 1);
  endtask

  task automatic check_sweep(input string tag, input int s,
                             input int e, input int st,
                             input int r);
    int rr;
    model(s, e, st);
    rr = (r == 0) ? 1 : r;
    check({tag, "_ncodes"}, codes.size(), exp_codes.size());
    foreach (exp_codes[j]) begin
      check({tag, "_code"},
            (j < codes.size()) ? codes[j] : -1, exp_codes[j]);
    end
    check({tag, "_daq"}, daq_t.size(), exp_codes.size() * rr);
    check({tag, "_strobe"}, strobe_cnt, exp_codes.size());
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_runcnt"}, 32'(Run_Count), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int s;
    int e;
    int st;
    int r;
    bit found;
    clear_log();
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", 32'(Busy), 0);
    check("rst_screq", 32'(Sc_Req), 0);
    check("rst_scdac", 32'(Sc_Dac), 0);
    check("rst_daq", 32'(Daq_Start), 0);
    check("rst_strobe", 32'(Step_Strobe), 0);
    check("rst_done", 32'(Sweep_Done), 0);
    check("rst_tmo", 32'(Timeout_Err), 0);
    check("rst_runcnt", 32'(Run_Count), 0);
    reset = 1'b0;
    repeat (2) @(posedge Clk);

    // basic sweep with latency checks
    sc_lat = 5;
    run_lat = 5;
    do_sweep(100, 104, 2, 3, 0, 2000, 1'b0);
    check_sweep("t1", 100, 104, 2, 3);
    check("lat_start_screq",
          (screq_t.size() > 0) ? screq_t[0] - start_t : -1, 2);
    check("lat_scdone_daq",
          (daq_t.size() > 0 && scdone_t.size() > 0) ?
          daq_t[0] - scdone_t[0] : -1, 2);
    check("lat_oe_daq",
          (daq_t.size() > 1 && oe_t.size() > 0) ?
          daq_t[1] - oe_t[0] : -1, 2);

    // zero step and zero runs behave as one
    do_sweep(500, 500, 0, 0, 0, 2000, 1'b0);
    check_sweep("t2", 500, 500, 0, 0);

    // no wrap past the top of the DAC range
    do_sweep(1020, 1023, 5, 1, 0, 2000, 1'b0);
    check_sweep("t3", 1020, 1023, 5, 1);

    // graceful stop during second run of four
    do_sweep(10, 20, 1, 4, 2, 2000, 1'b0);
    check("stop_daq", daq_t.size(), 2);
    check("stop_strobe", strobe_cnt, 0);
    check("stop_done", done_cnt, 1);
    check("stop_done_lat",
          (oe_t.size() > 0) ? done_t - oe_t[$] : -1, 2);
    check("stop_runcnt", 32'(Run_Count), 2);

    // start and stop together: load only, then done
    do_sweep(30, 40, 1, 2, 0, 2000, 1'b1);
    check("both_ncodes", codes.size(), 1);
    check("both_code", (codes.size() > 0) ? codes[0] : -1, 30);
    check("both_daq", daq_t.size(), 0);
    check("both_strobe", strobe_cnt, 0);
    check("both_done", done_cnt, 1);

    // watchdog in WAIT_RUN
    hold_run = 1'b1;
    do_sweep(200, 210, 1, 1, 0, 500, 1'b0);
    check("tmo_flag", 32'(Timeout_Err), 1);
    check("tmo_cycle",
          (daq_t.size() > 0 && tmo_t >= 0) ?
          tmo_t - daq_t[0] : -1, TO);
    check("tmo_busy", 32'(Busy), 0);
    check("tmo_screq", 32'(Sc_Req), 0);
    check("tmo_done", done_cnt, 0);
    hold_run = 1'b0;
    do_sweep(7, 7, 1, 1, 0, 2000, 1'b0);
    check("tmo_cleared", 32'(Timeout_Err), 0);
    check_sweep("t6", 7, 7, 1, 1);

    // randomized sweeps with stray handshake pulses
    for (int i = 0; i < 8; i++) begin
      s = (i % 3 == 0) ? int'($urandom_range(1023, 1000)) :
                         int'($urandom_range(999, 0));
      if (i % 4 == 3) begin
        e = (s > 10) ? s - int'($urandom_range(10, 1)) : s;
      end else begin
        e = s + int'($urandom_range(24, 0));
        if (e > 1023) e = 1023;
      end
      st = int'($urandom_range(7, 0));
      r = int'($urandom_range(3, 0));
      sc_lat = int'($urandom_range(8, 1));
      run_lat = int'($urandom_range(8, 1));
      stray = (i % 2 == 1);
      do_sweep(s, e, st, r, 0, 4000, 1'b0);
      check_sweep("rand", s, e, st, r);
    end
    stray = 1'b0;

    // asynchronous reset while waiting for slow control
    sc_lat = 40;
    clear_log();
    Dac_Start = DW'(300);
    Dac_End = DW'(310);
    Dac_Step = DW'(1);
    Runs_Per_Step = RW'(1);
    @(posedge Clk); #1;
    Sweep_Start = 1'b1;
    @(posedge Clk); #1;
    Sweep_Start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      if (Sc_Req) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_mid_screq_seen", 32'(found), 1);
    repeat (3) @(posedge Clk);
    @(negedge Clk); #2;
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 32'(Busy), 0);
    check("rst_mid_screq", 32'(Sc_Req), 0);
    check("rst_mid_scdac", 32'(Sc_Dac), 0);
    check("rst_mid_daq", 32'(Daq_Start), 0);
    check("rst_mid_tmo", 32'(Timeout_Err), 0);
    check("rst_mid_runcnt", 32'(Run_Count), 0);
    @(posedge Clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    check("rst_after_busy", 32'(Busy), 0);
    check("rst_after_screq", 32'(Sc_Req), 0);
    check("rst_after_daq", daq_t.size(), 0);
    sc_lat = 5;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/scurve_daq_sequencer.md
Name: scurve_daq_sequencer

Overview:
- Sweeps the Microroc DAC threshold from a start code to an end code and runs a programmed number of acquisitions at each code.
- Per step: requests a slow-control reload of the new threshold, then triggers the acquisition controller once per run and waits for its Once_end pulse.
- Sits between the USB command decoder and the acquisition controller / slow-control loader; used for S-curve scans.

Parameters:
DAC_WIDTH, 10, threshold DAC code width
RUN_WIDTH, 16, runs-per-step counter width
TIMEOUT_CYCLES, 4000000, watchdog limit in Clk cycles (100 ms at 40 MHz); 0 disables watchdog

Ports:
Clk  in  1  40 MHz system clock
reset  in  1  asynchronous reset, active high
Sweep_Start  in  1  one-cycle pulse, starts sweep (ignored unless idle)
Sweep_Stop  in  1  one-cycle pulse, graceful abort
Dac_Start  in  DAC_WIDTH  first threshold code
Dac_End  in  DAC_WIDTH  last threshold code
Dac_Step  in  DAC_WIDTH  code increment (0 treated as 1)
Runs_Per_Step  in  RUN_WIDTH  acquisitions per code (0 treated as 1)
Sc_Req  out  1  slow-control load request, level
Sc_Dac  out  DAC_WIDTH  threshold code to load
Sc_Done  in  1  one-cycle pulse, load finished
Daq_Start  out  1  one-cycle start pulse to acquisition controller
Once_end  in  1  one-cycle pulse, acquisition+readout finished
Busy  out  1  high in every state except IDLE
Step_Strobe  out  1  one-cycle pulse when all runs of a code are complete
Sweep_Done  out  1  one-cycle pulse on normal or aborted completion
Timeout_Err  out  1  sticky watchdog error flag
Run_Count  out  RUN_WIDTH  runs completed at current code

Behaviour:
- Reset: all outputs 0; Sc_Dac=0; state IDLE.
- Inputs sampled at the register level; all inputs are synchronous to Clk.
- Input latching: Dac_Start, Dac_End, Dac_Step and Runs_Per_Step are latched on Sweep_Start; later changes are ignored until the next sweep.
- IDLE: on Sweep_Start -> Timeout_Err cleared, cur=Dac_Start, Sc_Dac=Dac_Start, go LOAD_SC.
- LOAD_SC: Sc_Req=1 -> WAIT_SC.
- WAIT_SC: hold Sc_Req until Sc_Done; on Sc_Done, Sc_Req=0 next cycle -> START_RUN.
- START_RUN: Daq_Start=1 for exactly one cycle -> WAIT_RUN.
- WAIT_RUN: on Once_end, Run_Count+1.
  - If Run_Count+1 < runs -> START_RUN.
  - Otherwise -> NEXT_STEP.
- NEXT_STEP: Step_Strobe=1; Run_Count=0.
  - Compute nxt=cur+step in DAC_WIDTH+1 bits.
  - If cur>=Dac_End or nxt>Dac_End or nxt overflows DAC range -> DONE.
  - Otherwise cur=nxt, Sc_Dac=nxt -> LOAD_SC.
- DONE: Sweep_Done=1 for one cycle -> IDLE.
- Dac_Start>Dac_End: exactly one code (Dac_Start) is scanned.
- Sweep_Stop:
  - Recorded as a pending abort in any non-IDLE state.
  - Acquisition cycles are never cut: in WAIT_RUN the block waits for Once_end; in WAIT_SC it waits for Sc_Done.
  - It then goes to DONE without issuing further Daq_Start; Step_Strobe is not pulsed.
- Sweep_Stop and Sweep_Start in the same cycle while idle: start wins, and the abort is recorded immediately.
- Watchdog:
  - Cycle counter runs in WAIT_SC and WAIT_RUN and clears on state entry.
  - On reaching TIMEOUT_CYCLES: Timeout_Err=1, Sc_Req=0, go IDLE with no Sweep_Done.
- Once_end or Sc_Done arriving in a state not awaiting it is ignored.
- Latency: Sweep_Start to first Sc_Req = 2 cycles; Sc_Done to Daq_Start = 2 cycles; Once_end to next Daq_Start = 2 cycles.

Optional Feature:
SCURVE_TRIG_COUNT_EN
- With macro:
  - Adds input Trig_In (1-bit pulse) and outputs Trig_Count (32-bit) and Trig_Count_Valid.
  - Trig_In pulses are counted only in WAIT_RUN; the count saturates at all-ones.
  - Trig_Count is frozen and Trig_Count_Valid pulses together with Step_Strobe; the counter is cleared on entry to LOAD_SC.
- Without macro: the ports and logic are absent.

Decomposition:
- Package scurve_seq_pkg: state encoding (IDLE, LOAD_SC, WAIT_SC, START_RUN, WAIT_RUN, NEXT_STEP, DONE), default timeout constant, DAC_WIDTH default.
- One sub-module, seq_timeout_timer: loadable cycle counter with clear, enable and expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Start=100, End=104, Step=2, Runs=3; Sc_Done and Once_end returned after 5 cycles -> Sc_Dac sequence 100, 102, 104; 9 Daq_Start pulses; 3 Step_Strobe; 1 Sweep_Done.
- Step=0, Runs=0, Start=End=500 -> exactly one load of code 500, one Daq_Start, Sweep_Done.
- Start=1020, End=1023, Step=5 -> only code 1020 scanned; no wrap to 1.
- Sweep_Stop during the 2nd WAIT_RUN of 4 -> no Daq_Start after that run's Once_end; Sweep_Done 2 cycles later; no Step_Strobe.
- TIMEOUT_CYCLES=50, Once_end withheld -> Timeout_Err=1 at cycle 50 of WAIT_RUN, Busy=0; next Sweep_Start clears Timeout_Err.
- reset asserted mid-WAIT_SC -> all outputs 0 immediately; after release, Busy stays 0 until Sweep_Start.
